// File: rtl/pulse_train_sequencer.sv
// Burst sequencer for the toggling pulse-train generator: arms the generator, waits for done,
// times the synchronized echo rising edge and reports one latency result per burst.
module pulse_train_sequencer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned IDX_W   = 16,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] num_bursts,
    input  logic [CNT_W-1:0] gap_cycles,
    input  logic             gen_done,
    input  logic             echo,
    output logic             gen_reset,
    output logic             lat_valid,
    output logic             lat_timeout,
    output logic [CNT_W-1:0] lat_data,
    output logic [IDX_W-1:0] burst_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StWaitEcho,
        StReport,
        StGap,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] num_bursts_q, num_bursts_d;
    logic [CNT_W-1:0] gap_cycles_q, gap_cycles_d;
    logic [IDX_W-1:0] burst_idx_q, burst_idx_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] lat_data_q, lat_data_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             timed_out_q, timed_out_d;

    logic echo_s1_q, echo_s2_q, echo_s3_q;
    logic echo_rise;

    // Synchronizer plus delayed copy; runs in every state so that an echo that is
    // already high when WAIT_ECHO is entered never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
            echo_s3_q <= 1'b0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
        end
    end

    assign echo_rise = echo_s2_q & ~echo_s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            num_bursts_q <= '0;
            gap_cycles_q <= '0;
            burst_idx_q  <= '0;
            lat_cnt_q    <= '0;
            lat_data_q   <= '0;
            gap_cnt_q    <= '0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_bursts_q <= num_bursts_d;
            gap_cycles_q <= gap_cycles_d;
            burst_idx_q  <= burst_idx_d;
            lat_cnt_q    <= lat_cnt_d;
            lat_data_q   <= lat_data_d;
            gap_cnt_q    <= gap_cnt_d;
            timed_out_q  <= timed_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        num_bursts_d = num_bursts_q;
        gap_cycles_d = gap_cycles_q;
        burst_idx_d  = burst_idx_q;
        lat_cnt_d    = lat_cnt_q;
        lat_data_d   = lat_data_q;
        gap_cnt_d    = gap_cnt_q;
        timed_out_d  = timed_out_q;

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        num_bursts_d = num_bursts;
                        gap_cycles_d = gap_cycles;
                        burst_idx_d  = '0;
                        state_d      = (num_bursts == '0) ? StFin : StArm;
                    end
                end
                StArm: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (gen_done) begin
                        lat_cnt_d = '0;
                        state_d   = StWaitEcho;
                    end
                end
                StWaitEcho: begin
                    // An edge in the final counting cycle still wins over the timeout.
                    if (echo_rise) begin
                        lat_data_d  = lat_cnt_q;
                        timed_out_d = 1'b0;
                        state_d     = StReport;
                    end else if (lat_cnt_q == TimeoutLast) begin
                        lat_data_d  = TimeoutVal;
                        timed_out_d = 1'b1;
                        state_d     = StReport;
                    end else begin
                        lat_cnt_d = lat_cnt_q + CNT_W'(1);
                    end
                end
                StReport: begin
                    if (burst_idx_q == num_bursts_q - IDX_W'(1)) begin
                        state_d = StFin;
                    end else begin
                        burst_idx_d = burst_idx_q + IDX_W'(1);
                        if (gap_cycles_q != '0) begin
                            gap_cnt_d = gap_cycles_q;
                            state_d   = StGap;
                        end else begin
                            state_d = StArm;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q <= CNT_W'(1)) begin
                        state_d = StArm;
                    end else begin
                        gap_cnt_d = gap_cnt_q - CNT_W'(1);
                    end
                end
                StFin: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs decode the registered state only; no input reaches an output combinationally.
    always_comb begin
        gen_reset   = (state_q == StIdle) || (state_q == StArm) ||
                      (state_q == StGap)  || (state_q == StFin);
        lat_valid   = (state_q == StReport) && !timed_out_q;
        lat_timeout = (state_q == StReport) && timed_out_q;
        busy        = (state_q != StIdle);
        done        = (state_q == StFin);
        lat_data    = lat_data_q;
        burst_idx   = burst_idx_q;
    end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Randomized bench for pulse_train_sequencer: a schedule model derived from the timing rules
// predicts every output for every cycle of a run and drives generator/echo stimulus to match.
module tb_pulse_train_sequencer;

    localparam int CNT_W   = 32;
    localparam int IDX_W   = 16;
    localparam int TIMEOUT = 16;
    localparam int MAXC    = 256;
    localparam int MAXB    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] num_bursts;
    logic [CNT_W-1:0] gap_cycles;
    logic             gen_done;
    logic             echo;
    logic             gen_reset;
    logic             lat_valid;
    logic             lat_timeout;
    logic [CNT_W-1:0] lat_data;
    logic [IDX_W-1:0] burst_idx;
    logic             busy;
    logic             done;

    pulse_train_sequencer #(
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_bursts (num_bursts),
        .gap_cycles (gap_cycles),
        .gen_done   (gen_done),
        .echo       (echo),
        .gen_reset  (gen_reset),
        .lat_valid  (lat_valid),
        .lat_timeout(lat_timeout),
        .lat_data   (lat_data),
        .burst_idx  (burst_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got gr/v/to/busy/done=%b idx=%0d data=%0d, expected %b idx=%0d data=%0d",
                     tag, got[52:48], got[47:32], got[31:0], exp[52:48], exp[47:32], exp[31:0]);
        end
    endtask

    function automatic logic [63:0] observed();
        return {11'b0, gen_reset, lat_valid, lat_timeout, busy, done, burst_idx, lat_data};
    endfunction

    // Expected outputs and per-cycle stimulus for one run; cycle 0 is the cycle start is driven.
    logic [63:0] exp_out[MAXC];
    bit          stim_done[MAXC];
    bit          stim_echo[MAXC];
    int          d_arr[MAXB];
    int          n_arr[MAXB];
    int          lo_arr[MAXB];
    int          m_idx  = 0;
    logic [31:0] m_data = '0;

    task automatic put(input int c, input bit gr, input bit v, input bit to, input bit b,
                       input bit dn, input int idx, input logic [31:0] data);
        logic [15:0] idx16;
        idx16     = 16'(idx);
        exp_out[c] = {11'b0, gr, v, to, b, dn, idx16, data};
    endtask

    // d_arr: RUN cycles minus one before gen_done; n_arr: cycle after WAIT_ECHO entry at which
    // echo is driven high (-1 none); lo_arr: echo held high from before ARM until that offset.
    task automatic run_case(input string name, input int nb, input int gap, input int stop_at,
                            input bit stop_is_reset);
        int          t, w, lat, len, rep, arm, last_c, end_c, idx_s;
        bit          tmo;
        logic [31:0] cur_data, data_s;
        logic [63:0] e;
        for (int c = 0; c < MAXC; c++) begin
            stim_done[c] = 1'b0;
            stim_echo[c] = 1'b0;
        end
        cur_data = m_data;
        put(0, 1, 0, 0, 0, 0, m_idx, cur_data);
        t = 1;
        if (nb == 0) begin
            put(t, 1, 0, 0, 1, 1, 0, cur_data);
            t++;
        end
        for (int k = 0; k < nb; k++) begin
            arm = t;
            put(t, 1, 0, 0, 1, 0, k, cur_data);
            t++;
            for (int i = 0; i <= d_arr[k]; i++) begin
                put(t, 0, 0, 0, 1, 0, k, cur_data);
                t++;
            end
            w = t;
            if (n_arr[k] >= 0 && n_arr[k] + 2 <= TIMEOUT - 1) begin
                lat = n_arr[k] + 2;
                len = n_arr[k] + 3;
                tmo = 1'b0;
            end else begin
                lat = TIMEOUT;
                len = TIMEOUT;
                tmo = 1'b1;
            end
            for (int i = 0; i < len; i++) begin
                put(t, 0, 0, 0, 1, 0, k, cur_data);
                t++;
            end
            rep      = t;
            cur_data = 32'(lat);
            put(t, 0, !tmo, tmo, 1, 0, k, cur_data);
            for (int c = arm + 1 + d_arr[k]; c <= rep; c++) stim_done[c] = 1'b1;
            if (lo_arr[k] >= 0) begin
                for (int c = arm - 1; c < w + lo_arr[k]; c++) stim_echo[c] = 1'b1;
            end
            if (n_arr[k] >= 0) begin
                for (int c = w + n_arr[k]; c < rep; c++) stim_echo[c] = 1'b1;
            end
            t++;
            if (k == nb - 1) begin
                put(t, 1, 0, 0, 1, 1, k, cur_data);
                t++;
            end else begin
                for (int g = 0; g < gap; g++) begin
                    put(t, 1, 0, 0, 1, 0, k + 1, cur_data);
                    t++;
                end
            end
        end
        last_c = t;
        put(last_c, 1, 0, 0, 0, 0, (nb > 0) ? nb - 1 : 0, cur_data);
        put(last_c + 1, 1, 0, 0, 0, 0, (nb > 0) ? nb - 1 : 0, cur_data);
        end_c = last_c + 1;
        m_idx  = (nb > 0) ? nb - 1 : 0;
        m_data = cur_data;
        if (stop_at >= 0) begin
            e      = exp_out[stop_at];
            idx_s  = stop_is_reset ? 0 : int'(e[47:32]);
            data_s = stop_is_reset ? 32'd0 : e[31:0];
            for (int c = stop_at + 1; c <= stop_at + 4; c++) begin
                put(c, 1, 0, 0, 0, 0, idx_s, data_s);
                stim_done[c] = 1'b0;
                stim_echo[c] = 1'b0;
            end
            end_c  = stop_at + 4;
            m_idx  = idx_s;
            m_data = data_s;
        end
        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            check_val($sformatf("%s c%0d", name, c), observed(), exp_out[c]);
            start      = (c == 0);
            num_bursts = IDX_W'(nb);
            gap_cycles = CNT_W'(gap);
            gen_done   = stim_done[c];
            echo       = stim_echo[c];
            abort      = (c == stop_at) && !stop_is_reset;
            reset      = (c == stop_at) && stop_is_reset;
        end
    endtask

    task automatic set_burst(input int k, input int d, input int n, input int lo);
        d_arr[k]  = d;
        n_arr[k]  = n;
        lo_arr[k] = lo;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_bursts = '0;
        gap_cycles = '0;
        gen_done   = 1'b0;
        echo       = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_state", observed(), {11'b0, 5'b10000, 16'd0, 32'd0});
        reset = 1'b0;

        set_burst(0, 20, 5, -1);
        run_case("single", 1, 0, -1, 0);

        set_burst(0, 2, 3, -1);
        set_burst(1, 0, 0, -1);
        set_burst(2, 4, 10, -1);
        run_case("three_gap4", 3, 4, -1, 0);

        set_burst(0, 1, -1, -1);
        set_burst(1, 3, -1, -1);
        run_case("timeout", 2, 0, -1, 0);

        set_burst(0, 2, TIMEOUT - 3, -1);
        set_burst(1, 2, TIMEOUT - 2, -1);
        run_case("edge_vs_timeout", 2, 1, -1, 0);

        run_case("zero_bursts", 0, 3, -1, 0);

        set_burst(0, 5, 6, 3);
        run_case("echo_prehigh", 1, 0, -1, 0);

        set_burst(0, 2, 8, -1);
        set_burst(1, 2, 8, -1);
        run_case("reset_in_wait", 2, 0, 7, 1);

        set_burst(0, 1, 2, -1);
        set_burst(1, 1, 2, -1);
        set_burst(2, 1, 2, -1);
        run_case("abort_in_gap", 3, 5, 11, 0);

        set_burst(0, 1, 4, -1);
        run_case("after_abort", 1, 0, -1, 0);

        for (int r = 0; r < 20; r++) begin
            int nb, gap;
            nb  = int'($urandom_range(1, 4));
            gap = int'($urandom_range(0, 5));
            for (int k = 0; k < nb; k++) begin
                int d, n;
                d = int'($urandom_range(0, 6));
                if ($urandom_range(0, 3) == 0) n = -1;
                else n = int'($urandom_range(0, TIMEOUT - 1));
                set_burst(k, d, n, -1);
            end
            run_case($sformatf("rand%0d", r), nb, gap, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
